// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - shared constants and types for the system-control register block
//
// Purpose: IOC register addresses, the soft-reset key, the reset-length
// default, the pulse FSM state type and a length-clamp helper.
// Ports: none (package).

package sys_ctrl_pkg;

  localparam logic [4:0] IOC_MODULE_VERSION = 5'h00;
  localparam logic [4:0] IOC_SYSTEM_VERSION = 5'h01;
  localparam logic [4:0] IOC_MANU_ID        = 5'h02;
  localparam logic [4:0] IOC_ERR_STATE      = 5'h03;
  localparam logic [4:0] IOC_SOFT_RESET     = 5'h04;
  localparam logic [4:0] IOC_RESET_LEN      = 5'h05;
  localparam logic [4:0] IOC_ERR_MASK       = 5'h06;
  localparam logic [4:0] IOC_SCRATCH        = 5'h07;

  localparam logic [7:0] SOFT_RESET_KEY    = 8'hA5;
  localparam logic [7:0] RESET_LEN_DEFAULT = 8'd16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } pulse_state_e;

  // A programmed length of zero still produces a one-cycle pulse.
  function automatic logic [7:0] clamp_len(input logic [7:0] len);
    return (len == 8'd0) ? 8'd1 : len;
  endfunction

endpackage

// File: rtl/sys_ctrl_regs_if.sv
// rtl/sys_ctrl_regs_if.sv - IOC register bus interface
//
// Purpose: groups the IOC register-bus signals of the system-control block.
// Signals:
//   ioc       [4:0]  register address
//   data_in   [7:0]  write data
//   data_out  [7:0]  registered read data
//   cs               block select
//   fetch_cmd        read strobe, qualified by cs
//   load_cmd         write strobe, qualified by cs
// Modports: master drives the request, slave returns data_out.

interface sys_ctrl_regs_if;
  logic [4:0] ioc;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       cs;
  logic       fetch_cmd;
  logic       load_cmd;

  modport master (
    output ioc, data_in, cs, fetch_cmd, load_cmd,
    input  data_out
  );

  modport slave (
    input  ioc, data_in, cs, fetch_cmd, load_cmd,
    output data_out
  );
endinterface

// File: rtl/reset_pulse_gen.sv
// rtl/reset_pulse_gen.sv - keyed, programmable-length soft-reset pulse generator
//
// Purpose: two-state FSM (IDLE/PULSE) with an 8-bit down-counter. Reset
// enters PULSE with the POR length; a load strobe in IDLE starts a pulse of
// max(i_len, 1) cycles. Loads during PULSE are ignored.
// Ports:
//   i_sys_clk  clock
//   i_rst      asynchronous active-high reset
//   i_load     start request (already key-qualified by the caller)
//   i_len      [7:0] requested pulse length
//   o_pulse    high while in PULSE
//   o_busy     same as o_pulse
// Parameter: POR_LEN pulse length after reset release (1..255).

module reset_pulse_gen
  import sys_ctrl_pkg::*;
#(
  parameter int POR_LEN = 15
) (
  input  logic       i_sys_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_len,
  output logic       o_pulse,
  output logic       o_busy
);

  pulse_state_e state, state_next;
  logic [7:0]   count, count_next;

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_PULSE;
      count <= 8'(POR_LEN);
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      ST_IDLE: begin
        if (i_load) begin
          state_next = ST_PULSE;
          count_next = clamp_len(i_len);
        end
      end
      ST_PULSE: begin
        // The edge that sees count==1 is the last high cycle; <=1 also
        // guards against a zero count never terminating.
        if (count <= 8'd1) begin
          state_next = ST_IDLE;
          count_next = 8'd0;
        end else begin
          count_next = count - 8'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = 8'd0;
      end
    endcase
  end

  // state is a flop, so these outputs are registered.
  assign o_pulse = (state == ST_PULSE);
  assign o_busy  = (state == ST_PULSE);

endmodule

// File: rtl/sys_ctrl_regs.sv
// rtl/sys_ctrl_regs.sv - system-control register block on the IOC bus
//
// Purpose: RO identification registers, sticky W1C error capture with a
// maskable interrupt, a scratch register and a keyed soft-reset generator
// that also produces the power-on soft reset.
// Ports:
//   i_sys_clk     clock
//   i_rst         asynchronous active-high reset
//   bus           IOC register bus (slave side)
//   i_err         [N_ERR-1:0] error sources, sampled every cycle
//   o_err_irq     registered |(err_state & err_mask)
//   o_soft_reset  active-high soft reset to the rest of the FPGA
// Register map: 00/01/02 ids, 03 err_state (W1C), 04 soft_reset
// (write A5 / read busy), 05 reset_len, 06 err_mask, 07 scratch.

module sys_ctrl_regs
  import sys_ctrl_pkg::*;
#(
  parameter logic [7:0] MODULE_VERSION = 8'h02,
  parameter logic [7:0] SYSTEM_VERSION = 8'h01,
  parameter logic [7:0] MANU_ID        = 8'h01,
  parameter int         N_ERR          = 8,
  parameter int         POR_PULSE      = 15
) (
  input  logic             i_sys_clk,
  input  logic             i_rst,
  sys_ctrl_regs_if.slave   bus,
  input  logic [N_ERR-1:0] i_err,
  output logic             o_err_irq,
  output logic             o_soft_reset
);

  logic [N_ERR-1:0] err_state;
  logic [N_ERR-1:0] err_mask;
  logic [N_ERR-1:0] err_w1c;
  logic [7:0]       err_state_ext;
  logic [7:0]       err_mask_ext;
  logic [7:0]       reset_len;
  logic [7:0]       scratch;
  logic [7:0]       rd_data;
  logic             rd_en;
  logic             wr_en;
  logic             key_load;
  logic             busy;

  // A simultaneous fetch and load is treated as a read only.
  assign rd_en = bus.cs & bus.fetch_cmd;
  assign wr_en = bus.cs & bus.load_cmd & ~bus.fetch_cmd;

  assign key_load = wr_en && (bus.ioc == IOC_SOFT_RESET) && (bus.data_in == SOFT_RESET_KEY);

  // Zero-extend the N_ERR-wide registers to the 8-bit bus.
  always_comb begin
    err_state_ext = 8'h00;
    err_mask_ext  = 8'h00;
    err_state_ext[N_ERR-1:0] = err_state;
    err_mask_ext[N_ERR-1:0]  = err_mask;
  end

  always_comb begin
    err_w1c = '0;
    if (wr_en && (bus.ioc == IOC_ERR_STATE))
      err_w1c = bus.data_in[N_ERR-1:0];
  end

  always_comb begin
    rd_data = 8'h00;
    case (bus.ioc)
      IOC_MODULE_VERSION: rd_data = MODULE_VERSION;
      IOC_SYSTEM_VERSION: rd_data = SYSTEM_VERSION;
      IOC_MANU_ID:        rd_data = MANU_ID;
      IOC_ERR_STATE:      rd_data = err_state_ext;
      IOC_SOFT_RESET:     rd_data = {7'b0, busy};
      IOC_RESET_LEN:      rd_data = reset_len;
      IOC_ERR_MASK:       rd_data = err_mask_ext;
      IOC_SCRATCH:        rd_data = scratch;
      default:            rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.data_out <= 8'h00;
      err_state    <= '0;
      err_mask     <= '0;
      reset_len    <= RESET_LEN_DEFAULT;
      scratch      <= 8'h00;
      o_err_irq    <= 1'b0;
    end else begin
      if (rd_en)
        bus.data_out <= rd_data;

      if (wr_en) begin
        case (bus.ioc)
          IOC_RESET_LEN: reset_len <= bus.data_in;
          IOC_ERR_MASK:  err_mask  <= bus.data_in[N_ERR-1:0];
          IOC_SCRATCH:   scratch   <= bus.data_in;
          default: ;
        endcase
      end

      // Set is ORed after the clear so a coincident set wins.
      err_state <= (err_state & ~err_w1c) | i_err;
      o_err_irq <= |(err_state & err_mask);
    end
  end

  reset_pulse_gen #(
    .POR_LEN (POR_PULSE)
  ) u_pulse_gen (
    .i_sys_clk (i_sys_clk),
    .i_rst     (i_rst),
    .i_load    (key_load),
    .i_len     (reset_len),
    .o_pulse   (o_soft_reset),
    .o_busy    (busy)
  );

endmodule

// File: tb/tb_sys_ctrl_regs.sv
// tb/tb_sys_ctrl_regs.sv - scoreboard testbench for sys_ctrl_regs
//
// Purpose: directed stimulus pushes expected read data and expected
// soft-reset pulse widths into queues; independent monitors pop and compare.
// Ports: none (top-level bench).

module tb_sys_ctrl_regs;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] exp;
  } rd_exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] err;
  logic       err_irq;
  logic       soft_reset;

  sys_ctrl_regs_if bus();

  sys_ctrl_regs dut (
    .i_sys_clk    (clk),
    .i_rst        (rst),
    .bus          (bus),
    .i_err        (err),
    .o_err_irq    (err_irq),
    .o_soft_reset (soft_reset)
  );

  rd_exp_t rdq[$];
  int      pq[$];
  int      n_chk  = 0;
  int      n_pass = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Read monitor: a fetch sampled at a rising edge is compared at the
  // following falling edge.
  initial begin
    logic    fire;
    rd_exp_t e;
    forever begin
      @(posedge clk);
      fire = bus.cs && bus.fetch_cmd && !rst;
      @(negedge clk);
      if (fire) begin
        if (rdq.size() == 0) begin
          chk("read_unexpected", bus.data_out, 8'hxx);
        end else begin
          e = rdq.pop_front();
          chk($sformatf("read_ioc_%02h", e.addr), bus.data_out, e.exp);
        end
      end
    end
  end

  // Pulse monitor: counts high falling edges outside reset; a width is
  // compared when the pulse ends. Reset abandons any partial run.
  initial begin
    int run;
    int w;
    run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0;
      end else if (soft_reset === 1'b1) begin
        run++;
      end else if (run > 0) begin
        if (pq.size() == 0) begin
          chk("pulse_unexpected", 8'(run), 8'd0);
        end else begin
          w = pq.pop_front();
          chk("pulse_width", 8'(run), 8'(w));
        end
        run = 0;
      end
    end
  end

  // All bus tasks start and end 1 ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus.ioc = a; bus.data_in = d; bus.cs = 1'b1; bus.load_cmd = 1'b1;
    @(posedge clk);
    #1;
    bus.cs = 1'b0; bus.load_cmd = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp);
    rd_exp_t e;
    e.addr = a;
    e.exp  = exp;
    rdq.push_back(e);
    bus.ioc = a; bus.cs = 1'b1; bus.fetch_cmd = 1'b1;
    @(posedge clk);
    #1;
    bus.cs = 1'b0; bus.fetch_cmd = 1'b0;
  endtask

  // Checks o_err_irq at the next falling edge and consumes one cycle.
  task automatic expect_irq(input string name, input logic exp);
    @(negedge clk);
    chk(name, {7'b0, err_irq}, {7'b0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic err_pulse(input int bit_idx);
    err[bit_idx] = 1'b1;
    @(posedge clk);
    #1;
    err[bit_idx] = 1'b0;
  endtask

  initial begin
    rd_exp_t e;
    bus.ioc = 5'h00; bus.data_in = 8'h00; bus.cs = 1'b0;
    bus.fetch_cmd = 1'b0; bus.load_cmd = 1'b0;
    err = 8'h00;
    rst = 1'b0;

    // Reset and POR
    pq.push_back(15);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_soft_reset", {7'b0, soft_reset}, 8'h01);
    chk("rst_data_out", bus.data_out, 8'h00);
    chk("rst_err_irq", {7'b0, err_irq}, 8'h00);
    rst = 1'b0;
    rd(5'h00, 8'h02);
    rd(5'h01, 8'h01);
    rd(5'h02, 8'h01);
    rd(5'h1F, 8'h00);
    rd(5'h04, 8'h01);
    rd(5'h05, 8'h10);
    rd(5'h06, 8'h00);
    rd(5'h07, 8'h00);
    rd(5'h03, 8'h00);
    idle(20);
    rd(5'h04, 8'h00);

    // Soft reset with reset_len=3, bad key, zero length
    wr(5'h05, 8'h03);
    pq.push_back(3);
    wr(5'h04, 8'hA5);
    rd(5'h04, 8'h01);
    idle(6);
    wr(5'h04, 8'h5A);
    idle(5);
    rd(5'h04, 8'h00);
    wr(5'h05, 8'h00);
    pq.push_back(1);
    wr(5'h04, 8'hA5);
    idle(4);
    rd(5'h05, 8'h00);

    // Retrigger ignored during pulse
    wr(5'h05, 8'h0A);
    pq.push_back(10);
    wr(5'h04, 8'hA5);
    idle(3);
    wr(5'h04, 8'hA5);
    idle(12);

    // Unmapped write ignored
    wr(5'h1F, 8'h77);
    rd(5'h1F, 8'h00);

    // Error capture and W1C
    err_pulse(2);
    rd(5'h03, 8'h04);
    err[2] = 1'b1;
    wr(5'h03, 8'h04);
    idle(1);
    rd(5'h03, 8'h04);
    err[2] = 1'b0;
    wr(5'h03, 8'h04);
    rd(5'h03, 8'h00);
    // A set on the same edge as the read is not visible to that read
    err[0] = 1'b1;
    rd(5'h03, 8'h00);
    err[0] = 1'b0;
    rd(5'h03, 8'h01);
    wr(5'h03, 8'h01);
    expect_irq("irq_unmasked_off", 1'b0);

    // IRQ masking
    wr(5'h06, 8'h02);
    rd(5'h06, 8'h02);
    err_pulse(1);
    expect_irq("irq_one_after", 1'b0);
    expect_irq("irq_two_after", 1'b1);
    wr(5'h03, 8'h02);
    expect_irq("irq_clear_lag", 1'b1);
    expect_irq("irq_cleared", 1'b0);
    wr(5'h06, 8'h00);
    err_pulse(1);
    idle(3);
    expect_irq("irq_masked", 1'b0);
    rd(5'h03, 8'h02);
    wr(5'h06, 8'h02);
    idle(1);
    expect_irq("irq_stale_unmask", 1'b1);
    wr(5'h03, 8'hFF);
    idle(1);
    expect_irq("irq_after_clear_all", 1'b0);
    wr(5'h06, 8'hFF);
    rd(5'h06, 8'hFF);

    // Fetch/load collision: read wins, no write
    wr(5'h07, 8'h33);
    e.addr = 5'h07;
    e.exp  = 8'h33;
    rdq.push_back(e);
    bus.ioc = 5'h07; bus.data_in = 8'h55; bus.cs = 1'b1;
    bus.fetch_cmd = 1'b1; bus.load_cmd = 1'b1;
    @(posedge clk);
    #1;
    bus.cs = 1'b0; bus.fetch_cmd = 1'b0; bus.load_cmd = 1'b0;
    rd(5'h07, 8'h33);

    // Reset mid soft pulse: interrupted pulse is abandoned, POR follows
    wr(5'h05, 8'h0A);
    wr(5'h04, 8'hA5);
    err[3] = 1'b1;
    idle(3);
    err[3] = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_data_out", bus.data_out, 8'h00);
    chk("midrst_soft_reset", {7'b0, soft_reset}, 8'h01);
    chk("midrst_err_irq", {7'b0, err_irq}, 8'h00);
    pq.push_back(15);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rd(5'h07, 8'h00);
    rd(5'h05, 8'h10);
    rd(5'h06, 8'h00);
    rd(5'h03, 8'h00);
    idle(20);

    chk("read_queue_drained", 8'(rdq.size()), 8'd0);
    chk("pulse_queue_drained", 8'(pq.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sys_ctrl_regs.md
# sys_ctrl_regs

Parametrised system-control register block on the SPI IOC register bus: read-only identification registers, sticky write-1-to-clear error capture with a maskable interrupt, a scratch register, and a keyed, programmable-length soft-reset pulse generator. It sits at the system-control IOC address and drives the FPGA-wide soft reset. It also generates the power-on soft reset.

## Interface
- MODULE_VERSION, 8'h02: value returned at IOC 0x00.
- SYSTEM_VERSION, 8'h01: value returned at IOC 0x01.
- MANU_ID, 8'h01: value returned at IOC 0x02.
- N_ERR, 8: number of error sources, 1..8.
- POR_PULSE, 15: o_soft_reset cycles after i_rst release, 1..255.
- i_sys_clk  in  1  system clock; the block has one clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_ioc  in  5  register address.
- i_data_in  in  8  write data.
- o_data_out  out  8  read data, registered.
- i_cs  in  1  block select.
- i_fetch_cmd  in  1  read strobe, valid with i_cs.
- i_load_cmd  in  1  write strobe, valid with i_cs.
- i_err  in  N_ERR  error sources, active-high, sampled every cycle.
- o_err_irq  out  1  |(err_state & err_mask), registered.
- o_soft_reset  out  1  active-high soft reset to the rest of the FPGA.

## Operation
- Register map:
  - 0x00, 0x01, 0x02: RO identification registers.
  - 0x03 err_state: RO sticky bits, W1C.
  - 0x04 soft_reset: write 8'hA5 = request; read = {7'b0, busy}.
  - 0x05 reset_len: RW, reset value 8'd16.
  - 0x06 err_mask: RW, reset value 8'h00.
  - 0x07 scratch: RW, reset value 8'h00.
- Unused bits above N_ERR in err_state and err_mask read 0 and ignore writes.
- Unmapped IOC: reads return 8'h00; writes are ignored.
- Reads: when i_cs & i_fetch_cmd, o_data_out is loaded at the edge. Otherwise o_data_out holds its value.
- Writes: when i_cs & i_load_cmd & ~i_fetch_cmd, the target updates at the edge. If fetch and load are both high, the read wins and no write occurs.
- err_state[k] is set on any cycle where i_err[k]=1. A W1C of bit k clears it. If set and clear coincide, the set wins.
- Soft-reset FSM has two states, IDLE and PULSE, with an 8-bit down-counter.
  - IDLE -> PULSE on a write of 8'hA5 to 0x04. The counter loads max(reset_len, 1).
  - Any other value written to 0x04 is ignored.
  - Writes to 0x04 while in PULSE are ignored; no retrigger.
  - In PULSE the counter decrements each cycle. On the edge where the counter equals 1, the FSM returns to IDLE.
  - o_soft_reset = (state == PULSE), registered. busy equals the same signal.
- o_soft_reset does not reset this block. All registers survive a soft reset.
- Writing 0x05 during PULSE does not affect the current pulse.

## Timing
- i_rst asserted, all asynchronous:
  - state = PULSE, counter = POR_PULSE, o_soft_reset = 1.
  - o_data_out = 0, err_state = 0, o_err_irq = 0.
  - Registers take their reset values.
- After i_rst release, o_soft_reset stays high for exactly POR_PULSE rising edges, then drops.
- Read latency is 1 cycle: data is valid after the edge that samples fetch.
- Soft-reset request: o_soft_reset rises at the edge that samples the key write and stays high for exactly max(reset_len, 1) cycles.
- err_state is set at the edge that samples i_err. o_err_irq follows 1 cycle later.
- A read of 0x03 returns err_state as it was before that edge; a same-edge set is not visible.
- i_rst asserted mid-pulse restarts the POR sequence. reset_len reverts to 16.

## Structure
- Package sys_ctrl_pkg holds:
  - IOC address constants 0x00..0x07.
  - SOFT_RESET_KEY = 8'hA5.
  - RESET_LEN_DEFAULT = 8'd16.
- Sub-module reset_pulse_gen holds the FSM and down-counter.
  - Inputs: i_sys_clk, i_rst, load strobe, 8-bit length, POR length parameter.
  - Outputs: o_pulse, o_busy.
- Register decode and err logic stay in the top module.

## Test plan
- Reset and POR: hold i_rst for 3 cycles, then release.
  - o_soft_reset is high for exactly 15 edges after release.
  - Reads of 0x00/0x01/0x02 return 02/01/01; read of 0x1F returns 00.
- Soft reset: write 0x05 = 8'h03, then 0x04 = 8'hA5.
  - o_soft_reset is high for 3 cycles; a read of 0x04 mid-pulse returns 01.
  - A write of 8'h5A produces no pulse; reset_len = 0 gives a 1-cycle pulse.
- Retrigger: with reset_len = 10, write A5, then A5 again 4 cycles later.
  - One pulse of exactly 10 cycles results.
- Error capture: a 1-cycle pulse on i_err[2] -> read 0x03 returns 04.
  - W1C 04 while i_err[2] is held high -> bit stays 04.
  - W1C 04 after i_err[2] drops -> 00.
- IRQ masking: err_mask = 8'h02 with i_err[1] pulsed -> o_err_irq = 1 two cycles after the pulse.
  - With err_mask = 8'h00 -> o_err_irq stays 0.
  - Unmasking a stale bit raises o_err_irq.
- Collisions and reset: fetch & load together on 0x07 with data 8'h55 -> old scratch is returned and scratch is unchanged.
  - i_rst asserted mid soft-pulse -> scratch = 00, reset_len = 16, and a POR pulse of 15 follows.
